// File: rtl/poly_degree_scan_if.sv
// Coefficient stream and result bus for poly_degree_scan.
// lead_coef exists only when LEAD_COEF_EN is defined.
interface poly_degree_scan_if #(
    parameter int M  = 4,
    parameter int N  = 16,
    parameter int DW = $clog2(N)
) ();
    logic          start;
    logic          coef_valid;
    logic          coef_ready;
    logic [M-1:0]  coef;
    logic          coef_last;
    logic          busy;
    logic          res_valid;
    logic [DW-1:0] deg;
    logic          is_zero;
`ifdef LEAD_COEF_EN
    logic [M-1:0]  lead_coef;
`endif
    logic          overrun;

    modport master (
        output start, coef_valid, coef, coef_last,
`ifdef LEAD_COEF_EN
        input  lead_coef,
`endif
        input  coef_ready, busy, res_valid, deg, is_zero, overrun
    );

    modport slave (
        input  start, coef_valid, coef, coef_last,
`ifdef LEAD_COEF_EN
        output lead_coef,
`endif
        output coef_ready, busy, res_valid, deg, is_zero, overrun
    );
endinterface

// File: rtl/poly_degree_scan.sv
// Streams up to N GF(2^M) coefficients (lowest order first) and reports degree,
// zero flag, overrun and, when LEAD_COEF_EN is defined, the leading coefficient.
module poly_degree_scan #(
    parameter int M  = 4,
    parameter int N  = 16,
    parameter int DW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    poly_degree_scan_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state_q;
    logic [DW-1:0] idx_q;
    logic [DW-1:0] trk_deg_q, trk_deg_d;
    logic          nz_q, nz_d;
    logic          coef_ready_q;
    logic          busy_q;
    logic          res_valid_q;
    logic [DW-1:0] deg_q;
    logic          is_zero_q;
    logic          overrun_q;
    logic          accept;
    logic          at_max;
    logic          frame_end;
    logic          ovr_d;
`ifdef LEAD_COEF_EN
    logic [M-1:0]  lead_q, lead_d;
    logic [M-1:0]  lead_coef_q;
`endif

    // Zero polynomial reports degree 0 regardless of the tracked index.
    function automatic logic [DW-1:0] result_deg(input logic nz, input logic [DW-1:0] d);
        return nz ? d : '0;
    endfunction

    always_comb begin
        accept    = coef_ready_q && bus.coef_valid;
        at_max    = (idx_q == DW'(N - 1));
        frame_end = accept && (bus.coef_last || at_max);
        ovr_d     = accept && at_max && !bus.coef_last;
        trk_deg_d = trk_deg_q;
        nz_d      = nz_q;
`ifdef LEAD_COEF_EN
        lead_d    = lead_q;
`endif
        if (accept && (bus.coef != '0)) begin
            trk_deg_d = idx_q;
            nz_d      = 1'b1;
`ifdef LEAD_COEF_EN
            lead_d    = bus.coef;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            trk_deg_q    <= '0;
            nz_q         <= 1'b0;
            coef_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            deg_q        <= '0;
            is_zero_q    <= 1'b1;
            overrun_q    <= 1'b0;
`ifdef LEAD_COEF_EN
            lead_q       <= '0;
            lead_coef_q  <= '0;
`endif
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        idx_q        <= '0;
                        trk_deg_q    <= '0;
                        nz_q         <= 1'b0;
`ifdef LEAD_COEF_EN
                        lead_q       <= '0;
`endif
                        coef_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= SCAN;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        idx_q     <= idx_q + DW'(1);
                        trk_deg_q <= trk_deg_d;
                        nz_q      <= nz_d;
`ifdef LEAD_COEF_EN
                        lead_q    <= lead_d;
`endif
                    end
                    // Results are captured on the last-beat edge so they are valid during DONE.
                    if (frame_end) begin
                        coef_ready_q <= 1'b0;
                        res_valid_q  <= 1'b1;
                        deg_q        <= result_deg(nz_d, trk_deg_d);
                        is_zero_q    <= !nz_d;
                        overrun_q    <= ovr_d;
`ifdef LEAD_COEF_EN
                        lead_coef_q  <= nz_d ? lead_d : '0;
`endif
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    coef_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.coef_ready = coef_ready_q;
    assign bus.busy       = busy_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.deg        = deg_q;
    assign bus.is_zero    = is_zero_q;
    assign bus.overrun    = overrun_q;
`ifdef LEAD_COEF_EN
    assign bus.lead_coef  = lead_coef_q;
`endif

endmodule

// File: doc/poly_degree_scan.md
# poly_degree_scan

Sequential, parametrised polynomial degree finder for the Reed-Solomon decoder datapath. Accepts a polynomial over GF(2^M) as a stream of up to N coefficients, lowest order first, through a valid/ready handshake. Reports degree, zero flag and, optionally, leading coefficient. It sits between the Berlekamp-Massey / Euclid stages and the Chien search and Forney stages, where error-locator and evaluator degrees must be known.

## Interface
Parameters:
- M, 4, symbol width in bits (GF(2^M) element)
- N, 16, maximum coefficient count per polynomial (max degree N-1); N >= 2
- DW, $clog2(N), degree/index width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a new polynomial; honoured only in IDLE
- coef_valid  input  1  coef holds a valid coefficient
- coef_ready  output  1  block accepts a coefficient this cycle
- coef  input  M  coefficient value, index 0 first
- coef_last  input  1  marks final coefficient of the frame
- busy  output  1  high in SCAN and DONE
- res_valid  output  1  one-cycle pulse: results updated
- deg  output  DW  index of highest nonzero coefficient; 0 if zero polynomial
- is_zero  output  1  all accepted coefficients were zero
- lead_coef  output  M  value of coefficient at deg (only with LEAD_COEF_EN)
- overrun  output  1  frame reached N beats without coef_last

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: coef_ready=0, busy=0. A start in IDLE clears the internal index, track-degree, nonzero and lead registers, then moves to SCAN. Coefficients presented in IDLE are ignored.
- SCAN: coef_ready=1. A beat is accepted when coef_valid and coef_ready are both high.
  - Accepted beat at index i with coef != 0: the tracked degree becomes i, the nonzero flag is set, and lead becomes coef.
  - The index increments on every accepted beat.
  - A later nonzero always overrides an earlier one, so the result is the highest nonzero index.
- Frame end is the first of:
  - an accepted beat with coef_last=1;
  - the accepted beat at index N-1. If coef_last was 0 on that beat, the overrun flag is latched and the frame is treated as ended.
  - Either way the block moves to DONE.
- DONE: lasts one cycle. deg, is_zero, lead_coef and overrun are registered from the tracked values, res_valid=1, then the block returns to IDLE.
- Outputs hold their last result until the next DONE. start does not clear them.
- start asserted in SCAN or DONE is ignored and is not queued.
- A frame of a single zero beat gives deg=0, is_zero=1.
- is_zero=1 always forces deg=0 and lead_coef=0.

## Timing
- Reset (asynchronous assert, synchronous release): the FSM goes to IDLE. coef_ready=0, busy=0, res_valid=0, deg=0, is_zero=1, lead_coef=0, overrun=0.
- start sampled at cycle t gives coef_ready=1 from t+1.
- Throughput: one coefficient per cycle while coef_valid is held high. coef_valid gaps stall the scan without loss.
- Last beat accepted at cycle t: the block is in DONE at t+1 with res_valid high and outputs updated. It is back in IDLE at t+2, and the earliest new start is sampled at t+2.
- Total latency for a K-coefficient frame with no gaps: start to res_valid = K+1 cycles.
- rst_n asserted mid-SCAN: the frame is abandoned, all outputs take their reset values immediately, and no res_valid is produced.
- coef_ready is a registered function of state only. It does not depend combinationally on coef_valid.

## Configuration
- LEAD_COEF_EN defined: the lead_coef port exists, and the lead register tracks the value of the highest nonzero coefficient for use by Forney normalisation.
- LEAD_COEF_EN undefined: the lead_coef port and its register are removed. All other behaviour and timing are identical.

## Test plan
- Reset, then sample outputs: deg=0, is_zero=1, res_valid=0, coef_ready=0, overrun=0.
- M=4, N=16. start, then stream 4,0,7,0 with coef_last on beat 3 -> res_valid 5 cycles after start with deg=2, is_zero=0, lead_coef=7, overrun=0.
- Stream 0,0,0 with coef_last on beat 2 -> deg=0, is_zero=1, lead_coef=0.
- 16 beats, coef[15]=9, coef_last never asserted -> DONE after beat 15 with deg=15, lead_coef=9, overrun=1.
- Beats 1,0,3 with coef_valid low for 2 cycles between beats 1 and 2, and start pulsed during SCAN -> deg=2, lead_coef=3, res_valid 6 cycles after the first start, start ignored.
- rst_n pulsed low after beat 1 of a 4-beat frame -> no res_valid, outputs at reset values, next start completes normally.
